// File: rtl/uart_register_bridge.sv
// Decodes UART command packets into register bus reads/writes and returns a response packet.
// Build option REG_BRIDGE_NACK_EN: malformed packets addressed here get a one-byte 8'hFF NACK.
module uart_register_bridge #(
    parameter logic [7:0] LOCAL_ID = 8'h10,
    parameter int         ADDR_W   = 8
) (
    input  logic              ipClk,
    input  logic              ipReset,
    input  logic              ipRxValid,
    input  logic              ipRxSoP,
    input  logic              ipRxEoP,
    input  logic [7:0]        ipRxSource,
    input  logic [7:0]        ipRxDestination,
    input  logic [7:0]        ipRxLength,
    input  logic [7:0]        ipRxData,
    output logic [ADDR_W-1:0] opAddress,
    output logic [31:0]       opWrData,
    output logic              opWrEnable,
    output logic              opRdEnable,
    input  logic [31:0]       ipRdData,
    output logic              opTxValid,
    input  logic              ipTxReady,
    output logic              opTxSoP,
    output logic              opTxEoP,
    output logic [7:0]        opTxSource,
    output logic [7:0]        opTxDestination,
    output logic [7:0]        opTxLength,
    output logic [7:0]        opTxData,
    output logic              opBusy
);

`ifdef REG_BRIDGE_NACK_EN
    localparam logic NackEn = 1'b1;
`else
    localparam logic NackEn = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, RECEIVE, DISCARD, EXECUTE, READ_WAIT, RESPOND} state_t;

    state_t            state_q, state_d;
    logic [7:0]        opcode_q, opcode_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wrData_q, wrData_d;
    logic [31:0]       rdData_q, rdData_d;
    logic [2:0]        count_q, count_d;
    logic [2:0]        txIdx_q, txIdx_d;
    logic [7:0]        srcId_q, srcId_d;
    logic [7:0]        txLen_q, txLen_d;
    logic              nack_q, nack_d;
    logic              drop_q, drop_d;

    logic [2:0] newCount;
    logic       acceptSop;
    logic       cmdValid;
    logic       txEop;
    logic [7:0] addrByte;
    logic [7:0] txByte;

    assign newCount  = count_q + 3'd1;
    assign acceptSop = ipRxValid && ipRxSoP && (state_q == IDLE || state_q == RECEIVE);
    assign cmdValid  = ((opcode_q == 8'h00) && (ipRxLength == 8'd2) && (newCount == 3'd2)) ||
                       ((opcode_q == 8'h01) && (ipRxLength == 8'd6) && (newCount == 3'd6));
    assign txEop     = ({5'd0, txIdx_q} == (txLen_q - 8'd1));

    always_ff @(posedge ipClk) begin
        if (ipReset) begin
            state_q  <= IDLE;
            opcode_q <= '0;
            addr_q   <= '0;
            wrData_q <= '0;
            rdData_q <= '0;
            count_q  <= '0;
            txIdx_q  <= '0;
            srcId_q  <= '0;
            txLen_q  <= '0;
            nack_q   <= 1'b0;
            drop_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
            addr_q   <= addr_d;
            wrData_q <= wrData_d;
            rdData_q <= rdData_d;
            count_q  <= count_d;
            txIdx_q  <= txIdx_d;
            srcId_q  <= srcId_d;
            txLen_q  <= txLen_d;
            nack_q   <= nack_d;
            drop_q   <= drop_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        opcode_d = opcode_q;
        addr_d   = addr_q;
        wrData_d = wrData_q;
        rdData_d = rdData_q;
        count_d  = count_q;
        txIdx_d  = txIdx_q;
        srcId_d  = srcId_q;
        txLen_d  = txLen_q;
        nack_d   = nack_q;
        drop_d   = drop_q;

        // A packet that starts while a command is in flight is ignored up to its EoP.
        if (drop_q && ipRxValid && ipRxEoP) begin
            drop_d = 1'b0;
        end
        if (ipRxValid && ipRxSoP && !ipRxEoP &&
            (state_q == EXECUTE || state_q == READ_WAIT || state_q == RESPOND)) begin
            drop_d = 1'b1;
        end

        if (acceptSop) begin
            drop_d   = 1'b0;
            nack_d   = 1'b0;
            opcode_d = ipRxData;
            srcId_d  = ipRxSource;
            count_d  = 3'd1;
            if (ipRxDestination != LOCAL_ID) begin
                state_d = ipRxEoP ? IDLE : DISCARD;
            end else if (ipRxEoP) begin
                state_d = NackEn ? EXECUTE : IDLE;
                nack_d  = NackEn;
            end else begin
                state_d = RECEIVE;
            end
        end else begin
            case (state_q)
                RECEIVE: begin
                    if (ipRxValid) begin
                        count_d = newCount;
                        case (count_q)
                            3'd1:    addr_d          = ipRxData[ADDR_W-1:0];
                            3'd2:    wrData_d[7:0]   = ipRxData;
                            3'd3:    wrData_d[15:8]  = ipRxData;
                            3'd4:    wrData_d[23:16] = ipRxData;
                            3'd5:    wrData_d[31:24] = ipRxData;
                            default: ;
                        endcase
                        if (ipRxEoP) begin
                            if (cmdValid) begin
                                state_d = EXECUTE;
                            end else begin
                                state_d = NackEn ? EXECUTE : IDLE;
                                nack_d  = NackEn;
                            end
                        end else if (count_q == 3'd6) begin
                            state_d = DISCARD;
                            nack_d  = NackEn;
                        end
                    end
                end
                DISCARD: begin
                    if (ipRxValid && ipRxEoP) begin
                        state_d = nack_q ? EXECUTE : IDLE;
                    end
                end
                EXECUTE: begin
                    txIdx_d = '0;
                    if (nack_q) begin
                        state_d = RESPOND;
                        txLen_d = 8'd1;
                    end else if (opcode_q == 8'h01) begin
                        state_d = RESPOND;
                        txLen_d = 8'd2;
                    end else begin
                        state_d = READ_WAIT;
                    end
                end
                READ_WAIT: begin
                    rdData_d = ipRdData;
                    state_d  = RESPOND;
                    txLen_d  = 8'd6;
                    txIdx_d  = '0;
                end
                RESPOND: begin
                    if (ipTxReady) begin
                        if (txEop) begin
                            state_d = IDLE;
                        end else begin
                            txIdx_d = txIdx_q + 3'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        addrByte               = '0;
        addrByte[ADDR_W-1:0]   = addr_q;
    end

    // Response payload: opcode (or NACK marker), address, then read data LSB first.
    always_comb begin
        txByte = '0;
        case (txIdx_q)
            3'd0:    txByte = nack_q ? 8'hFF : opcode_q;
            3'd1:    txByte = addrByte;
            3'd2:    txByte = rdData_q[7:0];
            3'd3:    txByte = rdData_q[15:8];
            3'd4:    txByte = rdData_q[23:16];
            3'd5:    txByte = rdData_q[31:24];
            default: txByte = '0;
        endcase
    end

    assign opAddress       = addr_q;
    assign opWrData        = wrData_q;
    assign opWrEnable      = (state_q == EXECUTE) && !nack_q && (opcode_q == 8'h01);
    assign opRdEnable      = (state_q == EXECUTE) && !nack_q && (opcode_q == 8'h00);
    assign opTxValid       = (state_q == RESPOND);
    assign opTxSoP         = opTxValid && (txIdx_q == 3'd0);
    assign opTxEoP         = opTxValid && txEop;
    assign opTxSource      = opTxValid ? LOCAL_ID : 8'h00;
    assign opTxDestination = opTxValid ? srcId_q : 8'h00;
    assign opTxLength      = opTxValid ? txLen_q : 8'h00;
    assign opTxData        = opTxValid ? txByte : 8'h00;
    assign opBusy          = (state_q != IDLE);

endmodule

// File: tb/tb_uart_register_bridge.sv
// Scoreboard bench for uart_register_bridge: expected bus strobes and Tx bytes are queued per packet.
// Build with +define+REG_BRIDGE_NACK_EN to exercise the NACK responses.
module tb_uart_register_bridge;

    localparam logic [7:0] LOCAL_ID = 8'h10;

    typedef struct packed {
        logic [7:0] data;
        logic       sop;
        logic       eop;
        logic [7:0] dest;
        logic [7:0] len;
    } txExp_t;

    logic        ipClk = 1'b0;
    logic        ipReset = 1'b1;
    logic        ipRxValid = 1'b0;
    logic        ipRxSoP = 1'b0;
    logic        ipRxEoP = 1'b0;
    logic [7:0]  ipRxSource = 8'h00;
    logic [7:0]  ipRxDestination = 8'h00;
    logic [7:0]  ipRxLength = 8'h00;
    logic [7:0]  ipRxData = 8'h00;
    logic [31:0] ipRdData = 32'h5A5A_5A5A;
    logic        ipTxReady = 1'b1;
    logic [7:0]  opAddress;
    logic [31:0] opWrData;
    logic        opWrEnable, opRdEnable;
    logic        opTxValid, opTxSoP, opTxEoP, opBusy;
    logic [7:0]  opTxSource, opTxDestination, opTxLength, opTxData;

    txExp_t      expTx[$];
    logic [39:0] expWr[$];
    logic [7:0]  expRd[$];
    txExp_t      curTx;
    logic [39:0] curWr;
    logic [7:0]  curRd;

    int checks = 0;
    int errors = 0;
    int cycle = 0;
    int eopCycle = 0, wrCycle = 0, sopCycle = 0;
    int wrCount = 0, rdCount = 0, txCount = 0;
    bit inTxPkt = 1'b0;
    bit bpMode = 1'b0;
    int bpPhase = 0;
    logic [31:0] rdValue = 32'h0;

    uart_register_bridge #(.LOCAL_ID(LOCAL_ID), .ADDR_W(8)) dut (
        .ipClk(ipClk), .ipReset(ipReset),
        .ipRxValid(ipRxValid), .ipRxSoP(ipRxSoP), .ipRxEoP(ipRxEoP),
        .ipRxSource(ipRxSource), .ipRxDestination(ipRxDestination),
        .ipRxLength(ipRxLength), .ipRxData(ipRxData),
        .opAddress(opAddress), .opWrData(opWrData),
        .opWrEnable(opWrEnable), .opRdEnable(opRdEnable), .ipRdData(ipRdData),
        .opTxValid(opTxValid), .ipTxReady(ipTxReady),
        .opTxSoP(opTxSoP), .opTxEoP(opTxEoP),
        .opTxSource(opTxSource), .opTxDestination(opTxDestination),
        .opTxLength(opTxLength), .opTxData(opTxData), .opBusy(opBusy)
    );

    always #5 ipClk = ~ipClk;

    always @(posedge ipClk) cycle++;

    // Ready is high only one cycle in three while backpressure is enabled.
    always @(posedge ipClk) begin
        if (bpMode) begin
            bpPhase = (bpPhase + 1) % 3;
            #1 ipTxReady = (bpPhase == 0);
        end
    end

    // The register bus presents read data exactly one cycle after the read strobe, junk otherwise.
    always @(negedge ipClk) begin
        if (!ipReset && opRdEnable === 1'b1) begin
            @(posedge ipClk);
            #1 ipRdData = rdValue;
            @(posedge ipClk);
            #1 ipRdData = 32'h5A5A_5A5A;
        end
    end

    // Scoreboard: every strobe and presented Tx byte is matched against the queued expectations.
    always @(negedge ipClk) begin
        if (!ipReset) begin
            if (opWrEnable === 1'b1 && opRdEnable === 1'b1) begin
                checks++;
                errors++;
                $display("[TB] FAIL both_strobes wr=%b rd=%b want not both high", opWrEnable, opRdEnable);
            end
            if (opWrEnable === 1'b1) begin
                checks++;
                wrCount++;
                wrCycle = cycle;
                if (expWr.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL unexpected_write addr=%h data=%h want no write", opAddress, opWrData);
                end else begin
                    curWr = expWr.pop_front();
                    if ({opAddress, opWrData} !== curWr) begin
                        errors++;
                        $display("[TB] FAIL write_bus got=%h want=%h", {opAddress, opWrData}, curWr);
                    end
                end
            end
            if (opRdEnable === 1'b1) begin
                checks++;
                rdCount++;
                if (expRd.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL unexpected_read addr=%h want no read", opAddress);
                end else begin
                    curRd = expRd.pop_front();
                    if (opAddress !== curRd) begin
                        errors++;
                        $display("[TB] FAIL read_addr got=%h want=%h", opAddress, curRd);
                    end
                end
            end
            if (opTxValid === 1'b1) begin
                checks++;
                if (opTxSoP === 1'b1 && !inTxPkt) begin
                    sopCycle = cycle;
                    inTxPkt  = 1'b1;
                end
                if (expTx.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL unexpected_tx data=%h dest=%h len=%h want no tx", opTxData, opTxDestination, opTxLength);
                end else begin
                    curTx = expTx[0];
                    if ({opTxData, opTxSoP, opTxEoP, opTxSource, opTxDestination, opTxLength} !==
                        {curTx.data, curTx.sop, curTx.eop, LOCAL_ID, curTx.dest, curTx.len}) begin
                        errors++;
                        $display("[TB] FAIL tx_byte got data=%h sop=%b eop=%b src=%h dest=%h len=%h want data=%h sop=%b eop=%b src=%h dest=%h len=%h",
                                 opTxData, opTxSoP, opTxEoP, opTxSource, opTxDestination, opTxLength,
                                 curTx.data, curTx.sop, curTx.eop, LOCAL_ID, curTx.dest, curTx.len);
                    end
                    if (ipTxReady) void'(expTx.pop_front());
                end
                if (ipTxReady) begin
                    txCount++;
                    if (opTxEoP === 1'b1) inTxPkt = 1'b0;
                end
            end
        end
    end

    task automatic sendPacket(input logic [7:0] dest, input logic [7:0] src, input logic [7:0] len,
                              input logic [63:0] payload, input int n, input bit closeIt);
        for (int i = 0; i < n; i++) begin
            @(posedge ipClk);
            #1;
            ipRxValid       = 1'b1;
            ipRxSoP         = (i == 0);
            ipRxEoP         = closeIt && (i == n - 1);
            ipRxSource      = src;
            ipRxDestination = dest;
            ipRxLength      = len;
            ipRxData        = payload[8*i +: 8];
            if (ipRxEoP) eopCycle = cycle;
        end
        @(posedge ipClk);
        #1;
        ipRxValid = 1'b0;
        ipRxSoP   = 1'b0;
        ipRxEoP   = 1'b0;
        ipRxData  = 8'h00;
    endtask

    task automatic pushTx(input logic [7:0] dest, input logic [7:0] len, input logic [63:0] payload, input int n);
        txExp_t e;
        for (int i = 0; i < n; i++) begin
            e.data = payload[8*i +: 8];
            e.sop  = (i == 0);
            e.eop  = (i == n - 1);
            e.dest = dest;
            e.len  = len;
            expTx.push_back(e);
        end
    endtask

    task automatic waitIdle(input string tag);
        int n;
        n = 0;
        repeat (3) @(negedge ipClk);
        while ((opBusy !== 1'b0 || expTx.size() != 0) && n < 200) begin
            @(negedge ipClk);
            n++;
        end
        checks++;
        if (n >= 200) begin
            errors++;
            $display("[TB] FAIL %s_timeout busy=%b pendingTx=%0d want idle", tag, opBusy, expTx.size());
        end
        repeat (2) @(negedge ipClk);
    endtask

    task automatic test_reset();
        repeat (3) @(posedge ipClk);
        @(negedge ipClk);
        checks++;
        if ({opAddress, opWrData, opWrEnable, opRdEnable, opTxValid, opTxSoP, opTxEoP,
             opTxSource, opTxDestination, opTxLength, opTxData, opBusy} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_outputs got addr=%h wd=%h we=%b re=%b tv=%b busy=%b want all 0",
                     opAddress, opWrData, opWrEnable, opRdEnable, opTxValid, opBusy);
        end
        @(posedge ipClk);
        #1 ipReset = 1'b0;
    endtask

    task automatic test_write();
        int wr0;
        wr0 = wrCount;
        expWr.push_back({8'h22, 32'hDEAD_BEEF});
        pushTx(8'h01, 8'd2, 64'h2201, 2);
        sendPacket(8'h10, 8'h01, 8'd6, 64'h0000_DEAD_BEEF_2201, 6, 1'b1);
        waitIdle("write");
        checks++;
        if (wrCount - wr0 != 1) begin
            errors++;
            $display("[TB] FAIL write_count got=%0d want=1", wrCount - wr0);
        end
        checks++;
        if (wrCycle != eopCycle + 1) begin
            errors++;
            $display("[TB] FAIL write_latency got=%0d want=%0d", wrCycle - eopCycle, 1);
        end
        checks++;
        if (sopCycle != eopCycle + 2) begin
            errors++;
            $display("[TB] FAIL write_tx_latency got=%0d want=%0d", sopCycle - eopCycle, 2);
        end
        checks++;
        if (expWr.size() != 0) begin
            errors++;
            $display("[TB] FAIL write_missing got=%0d pending want=0", expWr.size());
        end
        expWr.delete();
    endtask

    task automatic test_read(input bit withBackpressure);
        int rd0, tx0;
        rd0 = rdCount;
        tx0 = txCount;
        rdValue = 32'hCAFE_F00D;
        bpMode = withBackpressure;
        expRd.push_back(8'h22);
        pushTx(8'h01, 8'd6, 64'h0000_CAFE_F00D_2200, 6);
        sendPacket(8'h10, 8'h01, 8'd2, 64'h2200, 2, 1'b1);
        waitIdle(withBackpressure ? "backpressure" : "read");
        bpMode = 1'b0;
        ipTxReady = 1'b1;
        checks++;
        if (rdCount - rd0 != 1) begin
            errors++;
            $display("[TB] FAIL read_count got=%0d want=1", rdCount - rd0);
        end
        checks++;
        if (txCount - tx0 != 6) begin
            errors++;
            $display("[TB] FAIL read_tx_accepts got=%0d want=6", txCount - tx0);
        end
        checks++;
        if (sopCycle != eopCycle + 3) begin
            errors++;
            $display("[TB] FAIL read_tx_latency got=%0d want=%0d", sopCycle - eopCycle, 3);
        end
        checks++;
        if (expRd.size() != 0) begin
            errors++;
            $display("[TB] FAIL read_missing got=%0d pending want=0", expRd.size());
        end
        expRd.delete();
        expTx.delete();
    endtask

    task automatic test_foreign();
        int wr0, tx0, rd0;
        wr0 = wrCount;
        tx0 = txCount;
        rd0 = rdCount;
        sendPacket(8'h20, 8'h01, 8'd6, 64'h0000_DEAD_BEEF_2201, 6, 1'b1);
        waitIdle("foreign");
        checks++;
        if (wrCount != wr0 || txCount != tx0) begin
            errors++;
            $display("[TB] FAIL foreign_ignored got wr=%0d tx=%0d want wr=0 tx=0", wrCount - wr0, txCount - tx0);
        end
        rdValue = 32'h1122_3344;
        expRd.push_back(8'h7A);
        pushTx(8'h05, 8'd6, 64'h0000_1122_3344_7A00, 6);
        sendPacket(8'h10, 8'h05, 8'd2, 64'h7A00, 2, 1'b1);
        waitIdle("foreign_read");
        checks++;
        if (rdCount - rd0 != 1 || expRd.size() != 0) begin
            errors++;
            $display("[TB] FAIL foreign_then_read got reads=%0d pending=%0d want reads=1 pending=0", rdCount - rd0, expRd.size());
        end
        expRd.delete();
    endtask

    task automatic test_malformed(input logic [7:0] len, input logic [63:0] payload, input int n, input string tag);
        int wr0, rd0;
        wr0 = wrCount;
        rd0 = rdCount;
`ifdef REG_BRIDGE_NACK_EN
        pushTx(8'h02, 8'd1, 64'hFF, 1);
`endif
        sendPacket(8'h10, 8'h02, len, payload, n, 1'b1);
        waitIdle(tag);
        checks++;
        if (wrCount != wr0 || rdCount != rd0) begin
            errors++;
            $display("[TB] FAIL %s_no_strobe got wr=%0d rd=%0d want 0 0", tag, wrCount - wr0, rdCount - rd0);
        end
`ifdef REG_BRIDGE_NACK_EN
        checks++;
        if (sopCycle != eopCycle + 2) begin
            errors++;
            $display("[TB] FAIL %s_nack_latency got=%0d want=%0d", tag, sopCycle - eopCycle, 2);
        end
`endif
    endtask

    task automatic test_restart();
        int wr0, rd0;
        wr0 = wrCount;
        rd0 = rdCount;
        rdValue = 32'h0102_0304;
        expRd.push_back(8'h55);
        pushTx(8'h03, 8'd6, 64'h0000_0102_0304_5500, 6);
        sendPacket(8'h10, 8'h03, 8'd6, 64'h4401, 2, 1'b0);
        sendPacket(8'h10, 8'h03, 8'd2, 64'h5500, 2, 1'b1);
        waitIdle("restart");
        checks++;
        if (wrCount != wr0 || rdCount - rd0 != 1) begin
            errors++;
            $display("[TB] FAIL restart_strobes got wr=%0d rd=%0d want wr=0 rd=1", wrCount - wr0, rdCount - rd0);
        end
        expRd.delete();
    endtask

    task automatic test_reset_midpacket();
        int wr0;
        wr0 = wrCount;
        sendPacket(8'h10, 8'h01, 8'd6, 64'h0000_DEAD_BEEF_2201, 3, 1'b0);
        #1 ipReset = 1'b1;
        @(posedge ipClk);
        @(negedge ipClk);
        checks++;
        if ({opAddress, opWrData, opWrEnable, opRdEnable, opTxValid, opBusy} !== '0) begin
            errors++;
            $display("[TB] FAIL midreset_outputs got addr=%h wd=%h we=%b busy=%b want all 0",
                     opAddress, opWrData, opWrEnable, opBusy);
        end
        @(posedge ipClk);
        #1 ipReset = 1'b0;
        waitIdle("midreset");
        checks++;
        if (wrCount != wr0) begin
            errors++;
            $display("[TB] FAIL midreset_no_write got=%0d want=0", wrCount - wr0);
        end
        expWr.push_back({8'h33, 32'h1234_5678});
        pushTx(8'h01, 8'd2, 64'h3301, 2);
        sendPacket(8'h10, 8'h01, 8'd6, 64'h0000_1234_5678_3301, 6, 1'b1);
        waitIdle("after_reset_write");
        checks++;
        if (wrCount - wr0 != 1 || expWr.size() != 0) begin
            errors++;
            $display("[TB] FAIL after_reset_write got=%0d pending=%0d want 1 0", wrCount - wr0, expWr.size());
        end
        expWr.delete();
    endtask

    initial begin
        $display("[TB] uart_register_bridge bench start");
        test_reset();
        test_write();
        test_read(1'b0);
        test_read(1'b1);
        test_foreign();
        test_malformed(8'd3, 64'h33_2201, 3, "bad_length");
        test_malformed(8'd8, 64'h7755_4433_2211_6601, 8, "overrun");
        test_malformed(8'd2, 64'h2207, 2, "bad_opcode");
        test_restart();
        test_reset_midpacket();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
